// File: rtl/midi_encoder_if.sv
// Message-in / byte-out handshake bundle for the MIDI encoder.
// The producer/consumer side uses master; the encoder uses slave.
interface midi_encoder_if;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       bad_status;

  modport master (
    output msg_status, msg_data1, msg_data2, msg_valid, data_out_ready,
    input  msg_ready, data_out, data_out_valid, bad_status
  );

  modport slave (
    input  msg_status, msg_data1, msg_data2, msg_valid, data_out_ready,
    output msg_ready, data_out, data_out_valid, bad_status
  );
endinterface

// File: rtl/midi_encoder.sv
// MIDI message serializer: one parsed message in, status + 0-2 data bytes out,
// with optional running-status suppression of repeated channel status bytes.
module midi_encoder #(
  parameter bit RUNNING_STATUS = 1'b1
) (
  input logic           clock_50_000_000,
  input logic           reset,
  midi_encoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, STATUS, DATA1, DATA2, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] status_q;
  logic [6:0] data1_q, data2_q;
  logic [1:0] len_q;
  logic [7:0] last_status, last_status_nxt;
  logic [7:0] data_out_nxt;
  logic       valid_nxt, bad_nxt, msg_ready_nxt;
  logic       accept, suppress;
  logic [1:0] in_len;

  // Wire length of a message; 0 marks an unsupported status byte.
  function automatic logic [1:0] msg_len(input logic [7:0] s);
    logic [1:0] n;
    n = 2'd0;
    if (s[7]) begin
      if (s < 8'hC0)      n = 2'd3;
      else if (s < 8'hE0) n = 2'd2;
      else if (s < 8'hF0) n = 2'd3;
      else begin
        case (s)
          8'hF1, 8'hF3: n = 2'd2;
          8'hF2:        n = 2'd3;
          8'hF6:        n = 2'd1;
          default:      n = (s >= 8'hF8) ? 2'd1 : 2'd0;
        endcase
      end
    end
    return n;
  endfunction

  function automatic logic is_channel(input logic [7:0] s);
    return s[7] && (s[7:4] != 4'hF);
  endfunction

  function automatic logic is_sys_common(input logic [7:0] s);
    return (s >= 8'hF1) && (s <= 8'hF6);
  endfunction

  assign accept   = bus.msg_valid && bus.msg_ready;
  assign in_len   = msg_len(bus.msg_status);
  assign suppress = RUNNING_STATUS && is_channel(bus.msg_status) &&
                    (bus.msg_status == last_status);

  always_comb begin
    state_nxt       = state;
    data_out_nxt    = bus.data_out;
    valid_nxt       = bus.data_out_valid;
    bad_nxt         = 1'b0;
    last_status_nxt = last_status;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_len == 2'd0) begin
            // Swallowed without touching the running-status register.
            state_nxt = DONE;
            bad_nxt   = 1'b1;
          end else begin
            if (is_channel(bus.msg_status))         last_status_nxt = bus.msg_status;
            else if (is_sys_common(bus.msg_status)) last_status_nxt = 8'h00;
            valid_nxt = 1'b1;
            if (suppress) begin
              state_nxt    = DATA1;
              data_out_nxt = {1'b0, bus.msg_data1};
            end else begin
              state_nxt    = STATUS;
              data_out_nxt = bus.msg_status;
            end
          end
        end
      end
      STATUS: begin
        if (bus.data_out_ready) begin
          if (len_q >= 2'd2) begin
            state_nxt    = DATA1;
            data_out_nxt = {1'b0, data1_q};
          end else begin
            state_nxt = DONE;
            valid_nxt = 1'b0;
          end
        end
      end
      DATA1: begin
        if (bus.data_out_ready) begin
          if (len_q == 2'd3) begin
            state_nxt    = DATA2;
            data_out_nxt = {1'b0, data2_q};
          end else begin
            state_nxt = DONE;
            valid_nxt = 1'b0;
          end
        end
      end
      DATA2: begin
        if (bus.data_out_ready) begin
          state_nxt = DONE;
          valid_nxt = 1'b0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
    msg_ready_nxt = (state_nxt == IDLE);
  end

  // Control and output registers; msg_ready stays low until the first edge after reset.
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      bus.msg_ready      <= 1'b0;
      bus.data_out_valid <= 1'b0;
      bus.data_out       <= 8'h00;
      bus.bad_status     <= 1'b0;
      last_status        <= 8'h00;
    end else begin
      state              <= state_nxt;
      bus.msg_ready      <= msg_ready_nxt;
      bus.data_out_valid <= valid_nxt;
      bus.data_out       <= data_out_nxt;
      bus.bad_status     <= bad_nxt;
      last_status        <= last_status_nxt;
    end
  end

  // Message capture; only read in states entered after an accept.
  always_ff @(posedge clock_50_000_000) begin
    if (accept) begin
      status_q <= bus.msg_status;
      data1_q  <= bus.msg_data1;
      data2_q  <= bus.msg_data2;
      len_q    <= in_len;
    end
  end

endmodule

// File: tb/tb_midi_encoder.sv
// Directed self-checking bench for midi_encoder; a second instance covers
// the running-status-disabled configuration.
module tb_midi_encoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  midi_encoder_if bus0 ();
  midi_encoder_if bus1 ();

  midi_encoder #(.RUNNING_STATUS(1'b1)) dut0 (
    .clock_50_000_000(clk), .reset(reset), .bus(bus0)
  );
  midi_encoder #(.RUNNING_STATUS(1'b0)) dut1 (
    .clock_50_000_000(clk), .reset(reset), .bus(bus1)
  );

  logic       sel = 1'b0;
  logic [7:0] st_tb = 8'h00;
  logic [6:0] d1_tb = 7'h00, d2_tb = 7'h00;
  logic       vld_tb = 1'b0, rdy_tb = 1'b0;

  assign bus0.msg_status     = st_tb;
  assign bus0.msg_data1      = d1_tb;
  assign bus0.msg_data2      = d2_tb;
  assign bus0.msg_valid      = vld_tb & ~sel;
  assign bus0.data_out_ready = rdy_tb;
  assign bus1.msg_status     = st_tb;
  assign bus1.msg_data1      = d1_tb;
  assign bus1.msg_data2      = d2_tb;
  assign bus1.msg_valid      = vld_tb & sel;
  assign bus1.data_out_ready = rdy_tb;

  logic       obs_ready, obs_valid, obs_bad;
  logic [7:0] obs_data;
  assign obs_ready = sel ? bus1.msg_ready      : bus0.msg_ready;
  assign obs_valid = sel ? bus1.data_out_valid : bus0.data_out_valid;
  assign obs_bad   = sel ? bus1.bad_status     : bus0.bad_status;
  assign obs_data  = sel ? bus1.data_out       : bus0.data_out;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for msg_ready, presents one message for exactly one edge.
  task automatic send_msg(input logic [7:0] s, input logic [6:0] a, input logic [6:0] b);
    for (int c = 0; c < 50 && !obs_ready; c++) step();
    chk("ready_wait", obs_ready, 1'b1);
    st_tb  = s;
    d1_tb  = a;
    d2_tb  = b;
    vld_tb = 1'b1;
    step();
    vld_tb = 1'b0;
  endtask

  // Drains the current message, checking byte count, values and hold stability.
  task automatic collect(input string tag, input int n, input logic [7:0] e0,
                         input logic [7:0] e1, input logic [7:0] e2, input bit rnd);
    logic [7:0] got [4];
    logic [7:0] exp_b [3];
    logic [7:0] held;
    bit holding;
    int k;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
    k = 0;
    holding = 1'b0;
    held = 8'h00;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    for (int c = 0; c < 60 && !obs_ready; c++) begin
      rdy_tb = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (holding) begin
        chk({tag, "_hold_vld"}, obs_valid, 1'b1);
        chk({tag, "_hold_data"}, obs_data, held);
      end
      if (obs_valid && rdy_tb) begin
        if (k < 4) got[k] = obs_data;
        k++;
        holding = 1'b0;
      end else if (obs_valid) begin
        holding = 1'b1;
        held = obs_data;
      end
      step();
    end
    rdy_tb = 1'b1;
    chk({tag, "_done"}, obs_ready, 1'b1);
    chk({tag, "_count"}, k, n);
    for (int i = 0; i < n && i < 3; i++) chk({tag, "_byte"}, got[i], exp_b[i]);
  endtask

  task automatic check_bad(input string tag, input logic [7:0] s);
    send_msg(s, 7'h11, 7'h22);
    chk({tag, "_bad_hi"}, obs_bad, 1'b1);
    chk({tag, "_no_vld"}, obs_valid, 1'b0);
    step();
    chk({tag, "_bad_lo"}, obs_bad, 1'b0);
    chk({tag, "_no_vld2"}, obs_valid, 1'b0);
    chk({tag, "_ready"}, obs_ready, 1'b1);
  endtask

  initial begin
    // Reset values
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", bus0.msg_ready, 1'b0);
    chk("rst_valid", bus0.data_out_valid, 1'b0);
    chk("rst_data", bus0.data_out, 8'h00);
    chk("rst_bad", bus0.bad_status, 1'b0);
    step(); step();
    reset = 1'b0;
    chk("rst_rel_ready", bus0.msg_ready, 1'b0);
    step();
    chk("post_rst_ready", bus0.msg_ready, 1'b1);

    // Cycle-exact Note On with ready held high
    rdy_tb = 1'b1;
    send_msg(8'h90, 7'h3C, 7'h64);
    chk("n1_b0_vld", obs_valid, 1'b1);
    chk("n1_b0", obs_data, 8'h90);
    chk("n1_busy", obs_ready, 1'b0);
    step();
    chk("n1_b1", obs_data, 8'h3C);
    step();
    chk("n1_b2", obs_data, 8'h64);
    chk("n1_b2_vld", obs_valid, 1'b1);
    step();
    chk("n1_done_vld", obs_valid, 1'b0);
    chk("n1_done_rdy", obs_ready, 1'b0);
    step();
    chk("n1_idle_rdy", obs_ready, 1'b1);

    // Running status on the default instance, always-status on the other
    send_msg(8'h90, 7'h40, 7'h00);
    collect("rs_on", 2, 8'h40, 8'h00, 8'h00, 1'b0);
    sel = 1'b1;
    send_msg(8'h90, 7'h40, 7'h00);
    collect("rs_off_a", 3, 8'h90, 8'h40, 8'h00, 1'b0);
    send_msg(8'h90, 7'h40, 7'h00);
    collect("rs_off_b", 3, 8'h90, 8'h40, 8'h00, 1'b0);
    sel = 1'b0;

    // Program change / real-time / system common interplay
    send_msg(8'hC1, 7'h05, 7'h00);
    collect("pc5", 2, 8'hC1, 8'h05, 8'h00, 1'b0);
    send_msg(8'hF8, 7'h00, 7'h00);
    collect("clk_rt", 1, 8'hF8, 8'h00, 8'h00, 1'b0);
    send_msg(8'hC1, 7'h06, 7'h00);
    collect("pc6", 1, 8'h06, 8'h00, 8'h00, 1'b0);
    send_msg(8'hF6, 7'h00, 7'h00);
    collect("tune", 1, 8'hF6, 8'h00, 8'h00, 1'b0);
    send_msg(8'hC1, 7'h07, 7'h00);
    collect("pc7", 2, 8'hC1, 8'h07, 8'h00, 1'b0);
    send_msg(8'hF2, 7'h01, 7'h02);
    collect("spp", 3, 8'hF2, 8'h01, 8'h02, 1'b0);

    // Backpressure
    send_msg(8'hB0, 7'h07, 7'h7F);
    collect("bp", 3, 8'hB0, 8'h07, 8'h7F, 1'b1);

    // Unsupported status leaves running status intact
    check_bad("sysex", 8'hF0);
    check_bad("nostat", 8'h45);
    send_msg(8'hB0, 7'h01, 7'h02);
    collect("after_bad", 2, 8'h01, 8'h02, 8'h00, 1'b0);

    // Reset while DATA1 is pending
    rdy_tb = 1'b0;
    send_msg(8'h90, 7'h3C, 7'h64);
    chk("mid_status", obs_data, 8'h90);
    rdy_tb = 1'b1;
    step();
    rdy_tb = 1'b0;
    chk("mid_data1", obs_data, 8'h3C);
    step();
    chk("mid_data1_hold", obs_data, 8'h3C);
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", obs_valid, 1'b0);
    chk("mid_rst_rdy", obs_ready, 1'b0);
    step();
    reset = 1'b0;
    chk("mid_rst_hold_vld", obs_valid, 1'b0);
    rdy_tb = 1'b1;
    send_msg(8'h90, 7'h3C, 7'h64);
    collect("post_rst", 3, 8'h90, 8'h3C, 8'h64, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
